ppu_requant: RTL and testbench

PPU_REQUANT -- requirements
Module: ppu_requant

---
 rtl/ppu_requant.sv | 236 +++++++++++++++++++++++
 tb/tb_ppu_requant.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_requant.sv
// Post-processing requantizer: scales, biases, rounds, optionally rectifies and saturates
// accumulator beats of one tile, then writes the narrowed lanes to an output RAM.
module ppu_requant #(
    parameter int LANES   = 16,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 4,
    parameter int SCALE_W = 16,
    parameter int FRAC    = 10,
    parameter int ROWS    = 16,
    parameter int ADDR_W  = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [ADDR_W-1:0]            i_base_addr,
    input  logic                         i_relu_en,
    input  logic                         i_acc_valid,
    input  logic [LANES*ACC_W-1:0]       i_acc_data,
    output logic                         o_acc_ready,
    input  logic                         i_cfg_we,
    input  logic                         i_cfg_sel,
    input  logic [$clog2(LANES)-1:0]     i_cfg_idx,
    input  logic [SCALE_W-1:0]           i_cfg_data,
    output logic                         o_ram_we,
    output logic [ADDR_W-1:0]            o_ram_addr,
    output logic [LANES*OUT_W-1:0]       o_ram_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [OUT_W-1:0]             o_absmax
);

    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int P_W   = ACC_W + SCALE_W + 2;
    localparam logic signed [P_W-1:0] ROUND_C = P_W'(2 ** (FRAC - 1));
    localparam logic signed [P_W-1:0] SAT_MAX = P_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Scale is unsigned, so it is zero-extended before entering the signed product.
    function automatic logic signed [P_W-1:0] lane_product(input logic [ACC_W-1:0] acc,
                                                           input logic [SCALE_W-1:0] scale,
                                                           input logic [SCALE_W-1:0] bias);
        logic signed [P_W-1:0] acc_x;
        logic signed [P_W-1:0] scale_x;
        logic signed [P_W-1:0] bias_x;
        acc_x   = {{(P_W-ACC_W){acc[ACC_W-1]}}, acc};
        scale_x = {{(P_W-SCALE_W){1'b0}}, scale};
        bias_x  = {{(P_W-SCALE_W){bias[SCALE_W-1]}}, bias};
        return (acc_x * scale_x) + (bias_x <<< FRAC);
    endfunction

    function automatic logic [OUT_W-1:0] requant_lane(input logic signed [P_W-1:0] p,
                                                      input logic relu);
        logic signed [P_W-1:0] r;
        logic [OUT_W-1:0]      res;
        r = (p + ROUND_C) >>> FRAC;
        if (relu && r[P_W-1]) begin
            res = '0;
        end else if (r > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = r[OUT_W-1:0];
        end
        return res;
    endfunction

    // The most negative code maps to 2^(OUT_W-1), which still fits the unsigned width.
    function automatic logic [OUT_W-1:0] abs_lane(input logic [OUT_W-1:0] v);
        return v[OUT_W-1] ? (~v + OUT_W'(1)) : v;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_W-1:0]       base_r;
    logic                    relu_r;
    logic [SCALE_W-1:0]      scale_r [LANES];
    logic [SCALE_W-1:0]      bias_r  [LANES];
    logic                    acc_fire_s;
    logic                    last_beat_s;
    logic signed [P_W-1:0]   p_s     [LANES];
    logic signed [P_W-1:0]   s1_p_r  [LANES];
    logic                    s1_valid_r;
    logic [ADDR_W-1:0]       s1_addr_r;
    logic [LANES*OUT_W-1:0]  s2_data_s;
    logic [LANES*OUT_W-1:0]  s2_data_r;
    logic                    s2_valid_r;
    logic [ADDR_W-1:0]       s2_addr_r;
    logic [OUT_W-1:0]        s2_max_s;
    logic [OUT_W-1:0]        absmax_acc_r;

    assign acc_fire_s  = i_acc_valid && (state_r == ST_RUN);
    assign last_beat_s = (cnt_r == CNT_W'(ROWS - 1));

    // Next-state logic for the tile sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (i_start) state_next_s = ST_RUN; else state_next_s = ST_IDLE;
            ST_RUN:   if (acc_fire_s && last_beat_s) state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
            ST_DRAIN: if (!s1_valid_r && !s2_valid_r) state_next_s = ST_DONE; else state_next_s = ST_DRAIN;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Per-lane full-precision product plus shifted bias for the incoming beat.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            p_s[k] = lane_product(i_acc_data[k*ACC_W +: ACC_W], scale_r[k], bias_r[k]);
        end
    end

    // Round, rectify and saturate stage-1 products.
    always_comb begin
        s2_data_s = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_data_s[k*OUT_W +: OUT_W] = requant_lane(s1_p_r[k], relu_r);
        end
    end

    // Largest magnitude among the lanes about to be written.
    always_comb begin
        s2_max_s = '0;
        for (int k = 0; k < LANES; k++) begin
            if (abs_lane(s2_data_r[k*OUT_W +: OUT_W]) > s2_max_s) begin
                s2_max_s = abs_lane(s2_data_r[k*OUT_W +: OUT_W]);
            end else begin
                s2_max_s = s2_max_s;
            end
        end
    end

    // Per-lane scale/bias registers, writable only between tiles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                scale_r[k] <= SCALE_W'(2 ** FRAC);
                bias_r[k]  <= '0;
            end
        end else if (i_cfg_we && (state_r == ST_IDLE)) begin
            if (i_cfg_sel) begin
                bias_r[i_cfg_idx] <= i_cfg_data;
            end else begin
                scale_r[i_cfg_idx] <= i_cfg_data;
            end
        end
    end

    // Sequencer state, beat counter, captured tile settings and running absmax.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            base_r       <= '0;
            relu_r       <= 1'b0;
            absmax_acc_r <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && i_start) begin
                cnt_r        <= '0;
                base_r       <= i_base_addr;
                relu_r       <= i_relu_en;
                absmax_acc_r <= '0;
            end else begin
                if (acc_fire_s) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                if (s2_valid_r && (s2_max_s > absmax_acc_r)) begin
                    absmax_acc_r <= s2_max_s;
                end
            end
        end
    end

    // Two-stage datapath: product capture, then rounded/saturated lanes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s2_valid_r <= 1'b0;
            s2_addr_r  <= '0;
            s2_data_r  <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_p_r[k] <= '0;
            end
        end else begin
            s1_valid_r <= acc_fire_s;
            s2_valid_r <= s1_valid_r;
            if (acc_fire_s) begin
                s1_addr_r <= base_r + ADDR_W'(cnt_r);
                for (int k = 0; k < LANES; k++) begin
                    s1_p_r[k] <= p_s[k];
                end
            end
            if (s1_valid_r) begin
                s2_addr_r <= s1_addr_r;
                s2_data_r <= s2_data_s;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_acc_ready <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_data  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_absmax    <= '0;
        end else begin
            o_acc_ready <= (state_next_s == ST_RUN);
            o_busy      <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
            o_done      <= (state_next_s == ST_DONE);
            o_ram_we    <= s2_valid_r;
            if (s2_valid_r) begin
                o_ram_addr <= s2_addr_r;
                o_ram_data <= s2_data_r;
            end
            if (state_next_s == ST_DONE) begin
                o_absmax <= absmax_acc_r;
            end
        end
    end

endmodule

// File: tb/tb_ppu_requant.sv
// Directed self-checking bench for ppu_requant: identity, saturation, rounding,
// ReLU/bias, address wrap with backpressure, and mid-tile reset.
module tb_ppu_requant;

    localparam int LANES  = 16;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 4;
    localparam int ADDR_W = 6;
    localparam int ROWS   = 16;

    logic                     clk;
    logic                     i_rst_n;
    logic                     i_start;
    logic [ADDR_W-1:0]        i_base_addr;
    logic                     i_relu_en;
    logic                     i_acc_valid;
    logic [LANES*ACC_W-1:0]   i_acc_data;
    logic                     o_acc_ready;
    logic                     i_cfg_we;
    logic                     i_cfg_sel;
    logic [3:0]               i_cfg_idx;
    logic [15:0]              i_cfg_data;
    logic                     o_ram_we;
    logic [ADDR_W-1:0]        o_ram_addr;
    logic [LANES*OUT_W-1:0]   o_ram_data;
    logic                     o_busy;
    logic                     o_done;
    logic [OUT_W-1:0]         o_absmax;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0]      wr_addr[$];
    logic [LANES*OUT_W-1:0] wr_data[$];

    ppu_requant dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_relu_en   (i_relu_en),
        .i_acc_valid (i_acc_valid),
        .i_acc_data  (i_acc_data),
        .o_acc_ready (o_acc_ready),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_sel   (i_cfg_sel),
        .i_cfg_idx   (i_cfg_idx),
        .i_cfg_data  (i_cfg_data),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_absmax    (o_absmax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect RAM writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (o_ram_we) begin
            wr_addr.push_back(o_ram_addr);
            wr_data.push_back(o_ram_data);
        end
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [3:0] idx, input logic [15:0] data);
        @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_idx = idx; i_cfg_data = data;
        @(negedge clk);
        i_cfg_we = 1'b0;
    endtask

    task automatic drive_lanes(input logic signed [ACC_W-1:0] a, input logic signed [ACC_W-1:0] b);
        for (int k = 0; k < LANES; k++) begin
            i_acc_data[k*ACC_W +: ACC_W] = (k % 2 == 0) ? a : b;
        end
    endtask

    // One full tile; even lanes get a, odd lanes b. With gap set, valid toggles,
    // a stray start and a config write are injected mid-tile.
    task automatic run_tile(input string tag, input logic [ADDR_W-1:0] base, input logic relu,
                            input logic signed [ACC_W-1:0] a, input logic signed [ACC_W-1:0] b,
                            input logic gap, input logic [63:0] exp_data, input logic [3:0] exp_max);
        int beats;
        int cyc;
        logic fire;
        logic [ADDR_W-1:0] ea;
        wr_addr.delete(); wr_data.delete(); done_cnt = 0;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_relu_en = relu;
        @(negedge clk);
        i_start = 1'b0; i_base_addr = '0; i_relu_en = ~relu;
        check({tag, "_busy"}, 64'(o_busy), 64'd1);
        beats = 0; cyc = 0;
        while (beats < ROWS && cyc < 200) begin
            i_acc_valid = gap ? (cyc % 2 == 0) : 1'b1;
            drive_lanes(a, b);
            if (gap && beats == 3) i_start = 1'b1;
            if (gap && beats == 5) begin
                i_cfg_we = 1'b1; i_cfg_sel = 1'b0; i_cfg_idx = 4'd0; i_cfg_data = 16'h0000;
            end
            fire = i_acc_valid && o_acc_ready;
            @(negedge clk);
            i_start = 1'b0; i_cfg_we = 1'b0;
            if (fire) beats++;
            cyc++;
        end
        i_acc_valid = 1'b0;
        check({tag, "_beats"}, 64'(beats), 64'd16);
        cyc = 0;
        while (done_cnt == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        check({tag, "_nwr"}, 64'(wr_addr.size()), 64'd16);
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_absmax"}, 64'(o_absmax), 64'(exp_max));
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
        for (int i = 0; i < wr_addr.size() && i < ROWS; i++) begin
            ea = base + ADDR_W'(i);
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(ea));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(o_acc_ready), 64'd0);
        check({tag, "_busy"},   64'(o_busy), 64'd0);
        check({tag, "_we"},     64'(o_ram_we), 64'd0);
        check({tag, "_done"},   64'(o_done), 64'd0);
        check({tag, "_absmax"}, 64'(o_absmax), 64'd0);
        check({tag, "_data"},   o_ram_data, 64'd0);
    endtask

    initial begin
        int beats;
        int cyc;
        logic fire;
        i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_relu_en = 1'b0;
        i_acc_valid = 1'b0; i_acc_data = '0; i_cfg_we = 1'b0; i_cfg_sel = 1'b0;
        i_cfg_idx = '0; i_cfg_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        i_rst_n = 1'b1;
        @(negedge clk);

        run_tile("ident", 6'd0, 1'b0, 24'sd3, 24'sd3, 1'b0, 64'h3333333333333333, 4'd3);
        run_tile("sat", 6'd16, 1'b0, 24'sd100, -24'sd100, 1'b0, 64'h8787878787878787, 4'd8);

        for (int k = 0; k < LANES; k++) cfg_write(1'b0, 4'(k), 16'h0200);
        run_tile("rnd3", 6'd32, 1'b0, 24'sd3, -24'sd3, 1'b0, 64'hF2F2F2F2F2F2F2F2, 4'd2);
        run_tile("rnd1", 6'd0, 1'b0, 24'sd1, 24'sd1, 1'b0, 64'h1111111111111111, 4'd1);

        for (int k = 0; k < LANES; k++) cfg_write(1'b0, 4'(k), 16'h0400);
        cfg_write(1'b1, 4'd0, 16'hFFFE);
        run_tile("relu", 6'd8, 1'b1, 24'sd1, 24'sd1, 1'b0, 64'h1111111111111110, 4'd1);
        run_tile("norelu", 6'd8, 1'b0, 24'sd1, 24'sd1, 1'b0, 64'h111111111111111F, 4'd1);

        cfg_write(1'b1, 4'd0, 16'h0000);
        run_tile("wrap", 6'd60, 1'b0, 24'sd2, -24'sd5, 1'b1, 64'hB2B2B2B2B2B2B2B2, 4'd5);

        // Disturb config so the reset must restore defaults.
        cfg_write(1'b0, 4'd3, 16'h0800);
        cfg_write(1'b1, 4'd2, 16'h0005);
        wr_addr.delete(); wr_data.delete(); done_cnt = 0;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 6'd0; i_relu_en = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 7 && cyc < 50) begin
            i_acc_valid = 1'b1;
            drive_lanes(24'sd3, 24'sd3);
            fire = o_acc_ready;
            @(negedge clk);
            if (fire) beats++;
            cyc++;
        end
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_mid");
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_addr.delete(); wr_data.delete(); done_cnt = 0;
        repeat (20) @(negedge clk);
        check("post_rst_nwr", 64'(wr_addr.size()), 64'd0);
        check("post_rst_done", 64'(done_cnt), 64'd0);
        check("post_rst_busy", 64'(o_busy), 64'd0);
        i_acc_valid = 1'b0;

        run_tile("after_rst", 6'd5, 1'b0, 24'sd3, 24'sd3, 1'b0, 64'h3333333333333333, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
